// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_REFUND = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 3'd1;
            COIN_10: return 3'd2;
            COIN_20: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int unsigned price(input int unsigned idx, input int unsigned step);
        return (idx + 1) * step;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with a global reload and an empty flag per product.
// Latency: decrement/reload take effect at the next edge; empty follows the counters directly.
// Backpressure: none; a decrement of an empty counter is dropped.
module vend_stock_bank #(
    parameter int unsigned NUM_PROD   = 10,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 8,
    parameter int unsigned SEL_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec,
    input  logic [SEL_W-1:0]    dec_idx,
    input  logic                restock,
    output logic [NUM_PROD-1:0] empty
);

    localparam logic [STOCK_W-1:0] INIT = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock [NUM_PROD];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PROD); i++) stock[i] <= INIT;
        end else if (restock) begin
            for (int i = 0; i < int'(NUM_PROD); i++) stock[i] <= INIT;
        end else begin
            for (int i = 0; i < int'(NUM_PROD); i++) begin
                if (dec && dec_idx == SEL_W'(i) && stock[i] != '0)
                    stock[i] <= stock[i] - 1'b1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int i = 0; i < int'(NUM_PROD); i++) empty[i] = (stock[i] == '0);
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending controller: coin credit, product selection, stock and serial change return.
// Latency: all outputs registered, one edge after the sampled inputs.
// Backpressure: none; inputs arriving while busy are rejected with coin_reject/sel_err.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int unsigned NUM_PROD   = 10,
    parameter int unsigned PRICE_STEP = 1,
    parameter int unsigned CREDIT_MAX = 10,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 8,
    parameter int unsigned SEL_W      = 4,
    localparam int unsigned CREDIT_W  = $clog2(CREDIT_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                restock,
    output logic [NUM_PROD-1:0] vend,
    output logic                change,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [NUM_PROD-1:0] empty
);

    localparam logic [CREDIT_W:0] CMAX  = (CREDIT_W + 1)'(CREDIT_MAX);
    localparam logic [SEL_W:0]    NPROD = (SEL_W + 1)'(NUM_PROD);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [NUM_PROD-1:0] vend_nxt;
    logic                change_nxt, rej_nxt, serr_nxt;
    logic                stock_dec, restock_en;
    logic [CREDIT_W:0]   sum, price_sel;
    logic                sel_ok;

    assign sum       = {1'b0, credit} + (CREDIT_W + 1)'(coin_value(coin));
    assign price_sel = (CREDIT_W + 1)'(price(32'(sel), PRICE_STEP));
    // Range check first so the empty lookup is only meaningful for a real product.
    assign sel_ok    = ({1'b0, sel} < NPROD) && !empty[sel] && ({1'b0, credit} >= price_sel);

    vend_stock_bank #(
        .NUM_PROD   (NUM_PROD),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT),
        .SEL_W      (SEL_W)
    ) u_stock (
        .clk     (clk),
        .reset   (reset),
        .dec     (stock_dec),
        .dec_idx (sel),
        .restock (restock_en),
        .empty   (empty)
    );

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        vend_nxt   = '0;
        change_nxt = 1'b0;
        rej_nxt    = 1'b0;
        serr_nxt   = 1'b0;
        stock_dec  = 1'b0;
        restock_en = 1'b0;
        case (state)
            ST_IDLE, ST_CREDIT: begin
                restock_en = (state == ST_IDLE) && restock;
                if (cancel && state == ST_CREDIT) begin
                    state_nxt  = ST_REFUND;
                    change_nxt = 1'b1;
                    rej_nxt    = (coin != COIN_NONE);
                end else if (sel_valid && sel_ok) begin
                    state_nxt  = ST_VEND;
                    credit_nxt = credit - price_sel[CREDIT_W-1:0];
                    vend_nxt   = NUM_PROD'(1) << sel;
                    stock_dec  = 1'b1;
                    rej_nxt    = (coin != COIN_NONE);
                end else begin
                    serr_nxt = sel_valid;
                    if (coin != COIN_NONE) begin
                        if (sum > CMAX) begin
                            rej_nxt = 1'b1;
                        end else begin
                            credit_nxt = sum[CREDIT_W-1:0];
                            state_nxt  = ST_CREDIT;
                        end
                    end
                end
            end
            ST_VEND: begin
                rej_nxt  = (coin != COIN_NONE);
                serr_nxt = sel_valid;
                if (credit != '0) begin
                    state_nxt  = ST_REFUND;
                    change_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REFUND: begin
                rej_nxt  = (coin != COIN_NONE);
                serr_nxt = sel_valid;
                if (credit <= CREDIT_W'(1)) begin
                    state_nxt  = ST_IDLE;
                    credit_nxt = '0;
                end else begin
                    credit_nxt = credit - 1'b1;
                    change_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            vend        <= '0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            vend        <= vend_nxt;
            change      <= change_nxt;
            coin_reject <= rej_nxt;
            sel_err     <= serr_nxt;
            busy        <= (state_nxt == ST_VEND) || (state_nxt == ST_REFUND);
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: expected output events are queued as stimulus is driven
// and matched against events captured from the DUT outputs.
module tb_vend_ctrl_param;

    localparam int NUM_PROD = 10;
    localparam int CREDIT_W = 4;
    localparam int K_VEND = 0, K_REJ = 1, K_SERR = 2, K_CHG = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          coin = 2'b00;
    logic                cancel = 1'b0;
    logic                sel_valid = 1'b0;
    logic [3:0]          sel = 4'd0;
    logic                restock = 1'b0;
    logic [NUM_PROD-1:0] vend;
    logic                change, coin_reject, sel_err, busy;
    logic [CREDIT_W-1:0] credit;
    logic [NUM_PROD-1:0] empty;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  passed = 0;
    int  chg_run = 0;

    vend_ctrl_param dut (
        .clk         (clk),
        .reset       (reset),
        .coin        (coin),
        .cancel      (cancel),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .restock     (restock),
        .vend        (vend),
        .change      (change),
        .coin_reject (coin_reject),
        .sel_err     (sel_err),
        .busy        (busy),
        .credit      (credit),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    // Event capture only; matching happens in the test tasks.
    always @(negedge clk) begin
        if (reset) begin
            chg_run = 0;
        end else begin
            if (vend != '0) begin
                int idx;
                idx = -1;
                for (int i = NUM_PROD - 1; i >= 0; i--) if (vend[i]) idx = i;
                obs_q.push_back('{kind: K_VEND, val: idx + 100 * ($countones(vend) - 1)});
            end
            if (coin_reject) obs_q.push_back('{kind: K_REJ, val: 0});
            if (sel_err)     obs_q.push_back('{kind: K_SERR, val: 0});
            if (change) chg_run++;
            else if (chg_run > 0) begin
                obs_q.push_back('{kind: K_CHG, val: chg_run});
                chg_run = 0;
            end
        end
    end

    task automatic cyc(input logic [1:0] c, input logic cn, input logic sv,
                       input logic [3:0] s, input logic rs);
        coin = c; cancel = cn; sel_valid = sv; sel = s; restock = rs;
        @(posedge clk);
        #1;
        coin = 2'b00; cancel = 1'b0; sel_valid = 1'b0; sel = 4'd0; restock = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (credit === 4'd0) passed++; else $display("FAIL reset_credit got %0d want 0", credit);
        checks++; if (vend === '0) passed++; else $display("FAIL reset_vend got %b want 0", vend);
        checks++; if (change === 1'b0) passed++; else $display("FAIL reset_change got %b want 0", change);
        checks++; if (busy === 1'b0) passed++; else $display("FAIL reset_busy got %b want 0", busy);
        checks++; if ({coin_reject, sel_err} === 2'b00) passed++;
        else $display("FAIL reset_err got %b want 00", {coin_reject, sel_err});
        checks++; if (empty === '0) passed++; else $display("FAIL reset_empty got %b want 0", empty);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_exact_change;
        ev_t e, o;
        cyc(2'b10, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (credit === 4'd2) passed++; else $display("FAIL exact_credit got %0d want 2", credit);
        exp_q.push_back('{kind: K_VEND, val: 1});
        cyc(2'b00, 1'b0, 1'b1, 4'd1, 1'b0);
        checks++; if (vend === 10'b00_0000_0010) passed++; else $display("FAIL exact_vend got %b want 0000000010", vend);
        checks++; if (busy === 1'b1) passed++; else $display("FAIL exact_busy got %b want 1", busy);
        checks++; if (credit === 4'd0) passed++; else $display("FAIL exact_credit_after got %0d want 0", credit);
        idle(1);
        checks++; if ({busy, change, vend} === '0) passed++;
        else $display("FAIL exact_idle got busy %b change %b vend %b want all 0", busy, change, vend);
        idle(10);
        checks++; if (obs_q.size() == exp_q.size()) passed++;
        else $display("FAIL exact_events count got %0d want %0d", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind == e.kind && o.val == e.val) passed++;
            else $display("FAIL exact_event got kind %0d val %0d want kind %0d val %0d", o.kind, o.val, e.kind, e.val);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_change_return;
        ev_t e, o;
        cyc(2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (credit === 4'd4) passed++; else $display("FAIL chg_credit got %0d want 4", credit);
        exp_q.push_back('{kind: K_VEND, val: 0});
        exp_q.push_back('{kind: K_CHG, val: 3});
        cyc(2'b00, 1'b0, 1'b1, 4'd0, 1'b0);
        idle(12);
        checks++; if (dut.u_stock.stock[0] === 4'd7) passed++;
        else $display("FAIL chg_stock0 got %0d want 7", dut.u_stock.stock[0]);
        checks++; if ({busy, credit} === '0) passed++;
        else $display("FAIL chg_end got busy %b credit %0d want 0 0", busy, credit);
        checks++; if (obs_q.size() == exp_q.size()) passed++;
        else $display("FAIL chg_events count got %0d want %0d", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind == e.kind && o.val == e.val) passed++;
            else $display("FAIL chg_event got kind %0d val %0d want kind %0d val %0d", o.kind, o.val, e.kind, e.val);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow;
        ev_t e, o;
        cyc(2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (credit === 4'd10) passed++; else $display("FAIL ovf_credit got %0d want 10", credit);
        exp_q.push_back('{kind: K_REJ, val: 0});
        cyc(2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (credit === 4'd10) passed++; else $display("FAIL ovf_credit_kept got %0d want 10", credit);
        cyc(2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++; if ({change, busy} === 2'b11) passed++;
        else $display("FAIL ovf_refund_start got change %b busy %b want 1 1", change, busy);
        // Inputs while refunding are bounced back.
        exp_q.push_back('{kind: K_REJ, val: 0});
        exp_q.push_back('{kind: K_SERR, val: 0});
        exp_q.push_back('{kind: K_CHG, val: 10});
        cyc(2'b01, 1'b0, 1'b1, 4'd0, 1'b0);
        idle(14);
        checks++; if ({busy, credit} === '0) passed++;
        else $display("FAIL ovf_end got busy %b credit %0d want 0 0", busy, credit);
        checks++; if (obs_q.size() == exp_q.size()) passed++;
        else $display("FAIL ovf_events count got %0d want %0d", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind == e.kind && o.val == e.val) passed++;
            else $display("FAIL ovf_event got kind %0d val %0d want kind %0d val %0d", o.kind, o.val, e.kind, e.val);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_errors;
        ev_t e, o;
        cyc(2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_q.push_back('{kind: K_SERR, val: 0});
        cyc(2'b00, 1'b0, 1'b1, 4'd4, 1'b0);
        checks++; if (credit === 4'd1) passed++; else $display("FAIL err_price_credit got %0d want 1", credit);
        exp_q.push_back('{kind: K_SERR, val: 0});
        cyc(2'b00, 1'b0, 1'b1, 4'd12, 1'b0);
        checks++; if (credit === 4'd1) passed++; else $display("FAIL err_range_credit got %0d want 1", credit);
        checks++; if (busy === 1'b0) passed++; else $display("FAIL err_busy got %b want 0", busy);
        exp_q.push_back('{kind: K_CHG, val: 1});
        cyc(2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(4);
        checks++; if (obs_q.size() == exp_q.size()) passed++;
        else $display("FAIL err_events count got %0d want %0d", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind == e.kind && o.val == e.val) passed++;
            else $display("FAIL err_event got kind %0d val %0d want kind %0d val %0d", o.kind, o.val, e.kind, e.val);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stock;
        ev_t e, o;
        cyc(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if (dut.u_stock.stock[0] === 4'd8) passed++;
        else $display("FAIL stock_reload got %0d want 8", dut.u_stock.stock[0]);
        for (int n = 0; n < 8; n++) begin
            cyc(2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
            exp_q.push_back('{kind: K_VEND, val: 0});
            cyc(2'b00, 1'b0, 1'b1, 4'd0, 1'b0);
            idle(2);
        end
        checks++; if (empty === 10'b00_0000_0001) passed++; else $display("FAIL stock_empty got %b want 0000000001", empty);
        cyc(2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_q.push_back('{kind: K_SERR, val: 0});
        cyc(2'b00, 1'b0, 1'b1, 4'd0, 1'b0);
        checks++; if (credit === 4'd1) passed++; else $display("FAIL stock_ninth_credit got %0d want 1", credit);
        cyc(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if (empty[0] === 1'b1) passed++; else $display("FAIL stock_restock_credit got %b want 1", empty[0]);
        exp_q.push_back('{kind: K_CHG, val: 1});
        cyc(2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(4);
        cyc(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if (empty === '0) passed++; else $display("FAIL stock_restock_idle got %b want 0", empty);
        checks++; if (dut.u_stock.stock[0] === 4'd8) passed++;
        else $display("FAIL stock_restock_val got %0d want 8", dut.u_stock.stock[0]);
        idle(2);
        checks++; if (obs_q.size() == exp_q.size()) passed++;
        else $display("FAIL stock_events count got %0d want %0d", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind == e.kind && o.val == e.val) passed++;
            else $display("FAIL stock_event got kind %0d val %0d want kind %0d val %0d", o.kind, o.val, e.kind, e.val);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_simultaneous;
        ev_t e, o;
        cyc(2'b10, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (credit === 4'd3) passed++; else $display("FAIL simul_credit got %0d want 3", credit);
        exp_q.push_back('{kind: K_REJ, val: 0});
        exp_q.push_back('{kind: K_CHG, val: 3});
        cyc(2'b10, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++; if ({change, credit} === {1'b1, 4'd3}) passed++;
        else $display("FAIL simul_start got change %b credit %0d want 1 3", change, credit);
        idle(8);
        checks++; if (obs_q.size() == exp_q.size()) passed++;
        else $display("FAIL simul_events count got %0d want %0d", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind == e.kind && o.val == e.val) passed++;
            else $display("FAIL simul_event got kind %0d val %0d want kind %0d val %0d", o.kind, o.val, e.kind, e.val);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_refund;
        cyc(2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(1);
        checks++; if ({change, credit} === {1'b1, 4'd3}) passed++;
        else $display("FAIL rstref_mid got change %b credit %0d want 1 3", change, credit);
        reset = 1'b1;
        #1;
        checks++; if ({change, busy, credit} === '0) passed++;
        else $display("FAIL rstref_async got change %b busy %b credit %0d want 0 0 0", change, busy, credit);
        checks++; if (empty === '0) passed++; else $display("FAIL rstref_empty got %b want 0", empty);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        checks++; if ({change, busy, credit} === '0) passed++;
        else $display("FAIL rstref_after got change %b busy %b credit %0d want 0 0 0", change, busy, credit);
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset;
        test_exact_change;
        test_change_return;
        test_overflow;
        test_errors;
        test_stock;
        test_simultaneous;
        test_reset_refund;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
